// File: rtl/demux_rr_dispatcher.sv
// +-----------------------------------------------------------------------+
// | demux_rr_dispatcher: one-entry holding stage that steers each word to |
// | one of N consumers, round-robin with stall skip or fixed destination. |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
`default_nettype none

module demux_rr_dispatcher #(
  parameter int N       = 8,
  parameter int SW      = $clog2(N),
  parameter int DW      = 8,
  parameter int TIMEOUT = 4,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          mode,
  input  logic [SW-1:0] dest,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  output logic [N-1:0]  out_valid,
  input  logic [N-1:0]  out_ready,
  output logic [DW-1:0] out_data,
  output logic [SW-1:0] sel,
  output logic          dest_err,
  output logic [CW-1:0] tx_count,
  output logic [CW-1:0] skip_count
);

  localparam int            TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SW:0]   N_EXT  = (SW+1)'(N);
  localparam logic [SW-1:0] LAST   = SW'(N-1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT-1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] ptr_q, ptr_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [DW-1:0] data_q, data_d;
  logic          held_mode_q, held_mode_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          dest_err_q, dest_err_d;
  logic [CW-1:0] tx_q, tx_d;
  logic [CW-1:0] skip_q, skip_d;

  function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] i);
    return (i == LAST) ? '0 : i + SW'(1);
  endfunction

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    sel_d       = sel_q;
    data_d      = data_q;
    held_mode_d = held_mode_q;
    timer_d     = timer_q;
    dest_err_d  = 1'b0;
    tx_d        = tx_q;
    skip_d      = skip_q;
    if (state_q == ST_IDLE) begin
      if (in_valid) begin
        state_d     = ST_HOLD;
        data_d      = in_data;
        held_mode_d = mode;
        timer_d     = '0;
        if (!mode) begin
          sel_d = ptr_q;
        end else if ({1'b0, dest} < N_EXT) begin
          sel_d = dest;
        end else begin
          sel_d      = '0;
          dest_err_d = 1'b1;
        end
      end
    end else begin
      // A ready consumer always beats an expiring timer.
      if (out_ready[sel_q]) begin
        state_d = ST_IDLE;
        tx_d    = tx_q + CW'(1);
        if (!held_mode_q) ptr_d = next_idx(sel_q);
      end else if (!held_mode_q) begin
        if (timer_q == T_LAST) begin
          sel_d   = next_idx(sel_q);
          timer_d = '0;
          skip_d  = skip_q + CW'(1);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      sel_q       <= '0;
      data_q      <= '0;
      held_mode_q <= 1'b0;
      timer_q     <= '0;
      dest_err_q  <= 1'b0;
      tx_q        <= '0;
      skip_q      <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      sel_q       <= sel_d;
      data_q      <= data_d;
      held_mode_q <= held_mode_d;
      timer_q     <= timer_d;
      dest_err_q  <= dest_err_d;
      tx_q        <= tx_d;
      skip_q      <= skip_d;
    end
  end

  assign in_ready   = (state_q == ST_IDLE);
  assign out_valid  = (state_q == ST_HOLD) ? (N'(1) << sel_q) : '0;
  assign out_data   = data_q;
  assign sel        = sel_q;
  assign dest_err   = dest_err_q;
  assign tx_count   = tx_q;
  assign skip_count = skip_q;

endmodule

`default_nettype wire

// File: doc/demux_rr_dispatcher.md
Name: demux_rr_dispatcher

Overview:
Sequencing controller for the 1-to-N demux datapath. Accepts words from a single valid/ready source and holds each one in a one-entry register. Drives it to exactly one of N consumers, selected either by a round-robin pointer or by a fixed destination. A consumer that stalls for too long in round-robin mode is skipped, so one dead output cannot block the stream.

Parameters:
N, 8, number of consumers / demux outputs (2..16)
SW, $clog2(N), width of select/destination/pointer fields
DW, 8, data word width
TIMEOUT, 4, HOLD cycles without out_ready[sel] before re-target (round-robin mode only, >=1)
CW, 16, width of transfer and skip counters

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous reset, active-high
mode  input  1  0 = round-robin, 1 = fixed destination; sampled at accept
dest  input  SW  fixed destination index; sampled at accept when mode=1
in_valid  input  1  source word valid
in_data  input  DW  source word
in_ready  output  1  dispatcher can accept a word
out_valid  output  N  one-hot valid to consumers; all-zero when nothing is held
out_ready  input  N  per-consumer ready
out_data  output  DW  held word, shared by all consumers
sel  output  SW  index currently targeted (demux select)
dest_err  output  1  one-cycle pulse: fixed dest >= N was accepted
tx_count  output  CW  completed transfers, wraps at 2^CW
skip_count  output  CW  timeout re-targets, wraps at 2^CW

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, ptr=0, sel=0, out_data=0, out_valid=0
  - tx_count=0, skip_count=0, dest_err=0, internal timer=0
  - rst takes priority over every other event, including mid-HOLD; the held word is discarded.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid = one-hot(sel).
  - in_ready is a combinational decode of state.
- IDLE -> HOLD when in_valid=1:
  - in_data is registered into out_data.
  - mode is latched into held_mode.
  - Round-robin: sel<=ptr.
  - Fixed, dest<N: sel<=dest.
  - Fixed, dest>=N: sel<=0 and dest_err pulses high for the next cycle only.
  - Timer cleared to 0.
- HOLD, out_ready[sel]=1: transfer completes that cycle.
  - state<=IDLE, tx_count+1.
  - If held_mode=0, ptr<=(sel+1) mod N.
  - If held_mode=1, ptr is unchanged.
  - out_ready on non-selected lines is ignored.
- HOLD, out_ready[sel]=0: timer+1.
  - If held_mode=0 and the timer reaches TIMEOUT-1 this cycle: sel<=(sel+1) mod N, timer<=0, skip_count+1. out_data is unchanged.
  - If held_mode=1: wait indefinitely, no skip.
- Simultaneous out_ready[sel]=1 and timeout: the transfer wins; no skip and no skip_count increment.
- Wrap-around: index N-1 wraps to 0 for both ptr and sel. Counters wrap silently.
- Throughput and latency:
  - Maximum throughput is one word per 2 cycles (accept cycle, then at least one HOLD cycle).
  - Latency from accept to the earliest out_valid is 1 cycle.
- Out-of-range rules:
  - mode/dest changes while in HOLD have no effect on the held word.
  - sel is always < N.
  - out_valid is never more than one-hot.

Test Plan:
- Reset then round-robin, all out_ready=1, in_valid=1 with in_data=0xA0..0xA8 (9 words) -> out_valid steps 0x01,0x02,…,0x80,0x01; 9th word goes to index 0; tx_count=9; in_ready alternates 1/0.
- Fixed mode, dest=3, out_ready=0x08 delayed 10 cycles, in_data=0x5C -> out_valid=0x08 held for 10 cycles with no skip; transfer on cycle 11; tx_count+1; ptr unchanged.
- Round-robin, ptr=2, out_ready[2]=0 permanently, others 1, TIMEOUT=4 -> sel 2 for 4 cycles, then sel=3, transfer; skip_count=1; next word targets 4.
- Round-robin, out_ready[5] asserted exactly on the 4th HOLD cycle with sel=5 -> transfer to 5; skip_count unchanged.
- N=6, fixed mode, dest=7 -> dest_err one-cycle pulse; sel=0; out_valid=0x01.
- rst asserted during HOLD (sel=4, data 0x3E) -> next cycle out_valid=0, in_ready=1, ptr=0, both counters 0; the word is never delivered.
